cpu_wb_seq_multiplier: RTL and testbench



---
 rtl/cpu_wb_seq_multiplier.sv | 194 +++++++++++++++++++
 tb/tb_cpu_wb_seq_multiplier.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_wb_seq_multiplier.sv
// Iterative unsigned shift-and-add multiplier driving one carry-lookahead adder.
// Optional registered overflow flag is built when CPU_WB_MUL_OVF_EN is defined.

module cpu_wb_cla_adder #(
  parameter int DATA_WID = 32
) (
  input  logic [DATA_WID-1:0] in1,
  input  logic [DATA_WID-1:0] in2,
  input  logic                carry_in,
  output logic [DATA_WID-1:0] sum,
  output logic                carry_out
);
  localparam int GRP_WID = 4;
  localparam int GRP_NUM = (DATA_WID + GRP_WID - 1) / GRP_WID;

  logic [GRP_NUM-1:0] grp_gen;
  logic [GRP_NUM-1:0] grp_prop;
  logic [GRP_NUM:0]   grp_carry;

  // Each 4-bit group (the top one may be narrower) produces its own generate/propagate
  genvar gi;
  generate
    for (gi = 0; gi < GRP_NUM; gi++) begin : g_grp
      localparam int BASE = gi * GRP_WID;
      localparam int W    = ((DATA_WID - BASE) < GRP_WID) ? (DATA_WID - BASE) : GRP_WID;

      logic [W-1:0] bit_gen;
      logic [W-1:0] bit_prop;
      logic [W-1:0] bit_carry;
      logic         blk_gen;
      logic         blk_prop;

      assign bit_gen  = in1[BASE +: W] & in2[BASE +: W];
      assign bit_prop = in1[BASE +: W] ^ in2[BASE +: W];

      always_comb begin
        blk_gen  = 1'b0;
        blk_prop = 1'b1;
        for (int k = 0; k < W; k++) begin
          blk_gen  = bit_gen[k] | (bit_prop[k] & blk_gen);
          blk_prop = blk_prop & bit_prop[k];
        end
      end

      always_comb begin
        bit_carry    = '0;
        bit_carry[0] = grp_carry[gi];
        for (int k = 1; k < W; k++) begin
          bit_carry[k] = bit_gen[k-1] | (bit_prop[k-1] & bit_carry[k-1]);
        end
      end

      assign grp_gen[gi]    = blk_gen;
      assign grp_prop[gi]   = blk_prop;
      assign sum[BASE +: W] = bit_prop ^ bit_carry;
    end
  endgenerate

  always_comb begin
    grp_carry    = '0;
    grp_carry[0] = carry_in;
    for (int i = 0; i < GRP_NUM; i++) begin
      grp_carry[i+1] = grp_gen[i] | (grp_prop[i] & grp_carry[i]);
    end
  end

  assign carry_out = grp_carry[GRP_NUM];

endmodule

module cpu_wb_seq_multiplier #(
  parameter int DATA_WID = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WID-1:0]   in1,
  input  logic [DATA_WID-1:0]   in2,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_WID-1:0] product,
  output logic                  ovf
);
  localparam int CNT_WID = $clog2(DATA_WID) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [DATA_WID-1:0]   mcand_reg;
  logic [DATA_WID-1:0]   acc_hi_reg;
  logic [DATA_WID-1:0]   acc_lo_reg;
  logic [CNT_WID-1:0]    cnt_reg;
  logic [2*DATA_WID-1:0] product_reg;
  logic                  done_reg;

  logic [DATA_WID-1:0] add_in2;
  logic [DATA_WID-1:0] add_sum;
  logic                add_cout;
  logic                last_step;
  logic                load_en;
  logic                step_en;
  logic                cap_en;

  assign add_in2   = acc_lo_reg[0] ? mcand_reg : '0;
  assign last_step = (cnt_reg == CNT_WID'(DATA_WID - 1));

  cpu_wb_cla_adder #(
    .DATA_WID (DATA_WID)
  ) u_cla (
    .in1       (acc_hi_reg),
    .in2       (add_in2),
    .carry_in  (1'b0),
    .sum       (add_sum),
    .carry_out (add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_RUN;
      ST_RUN:  if (last_step) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_reg == ST_RUN);
    load_en = (state_reg == ST_IDLE) && start;
    step_en = (state_reg == ST_RUN);
    cap_en  = (state_reg == ST_DONE);
  end

  // One step shifts the (2*DATA_WID+1)-bit {carry, sum, acc_lo} vector right by one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_reg   <= '0;
      acc_hi_reg  <= '0;
      acc_lo_reg  <= '0;
      cnt_reg     <= '0;
      product_reg <= '0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= cap_en;
      if (load_en) begin
        mcand_reg  <= in1;
        acc_lo_reg <= in2;
        acc_hi_reg <= '0;
        cnt_reg    <= '0;
      end else if (step_en) begin
        acc_hi_reg <= {add_cout, add_sum[DATA_WID-1:1]};
        acc_lo_reg <= {add_sum[0], acc_lo_reg[DATA_WID-1:1]};
        cnt_reg    <= cnt_reg + CNT_WID'(1);
      end
      if (cap_en) begin
        product_reg <= {acc_hi_reg, acc_lo_reg};
      end
    end
  end

`ifdef CPU_WB_MUL_OVF_EN
  logic ovf_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (cap_en) begin
      ovf_reg <= (acc_hi_reg != '0);
    end
  end

  assign ovf = ovf_reg;
`else
  assign ovf = 1'b0;
`endif

  assign done    = done_reg;
  assign product = product_reg;

endmodule

// File: tb/tb_cpu_wb_seq_multiplier.sv
// Self-checking bench for cpu_wb_seq_multiplier: vector table, corner sequences
// and randomized operands against a plain-arithmetic reference.

module tb_cpu_wb_seq_multiplier;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   in1 = '0;
  logic [W-1:0]   in2 = '0;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic           ovf;

  int n_cmp = 0;
  int n_bad = 0;
  logic [2*W-1:0] last_prod = '0;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
    bit             btb;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  cpu_wb_seq_multiplier #(
    .DATA_WID (W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .in1     (in1),
    .in2     (in2),
    .busy    (busy),
    .done    (done),
    .product (product),
    .ovf     (ovf)
  );

  function automatic logic exp_ovf(input logic [2*W-1:0] p);
`ifdef CPU_WB_MUL_OVF_EN
    return (p[2*W-1:W] != '0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] wa;
    logic [2*W-1:0] wb;
    wa = {{W{1'b0}}, a};
    wb = {{W{1'b0}}, b};
    return wa * wb;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents operands with start; returns just after the accepting edge E0
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    in1   = a;
    in2   = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Follows one operation from just after E0 until the done pulse
  task automatic finish(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp_p, input bit toggle, input string tag);
    int k;
    int busy_n;
    int lat;
    bit hold_ok;
    bit overlap;
    k = 0;
    busy_n = 0;
    lat = -1;
    hold_ok = 1'b1;
    overlap = 1'b0;
    while (k <= W + 4) begin
      if (busy && done) overlap = 1'b1;
      if (busy) busy_n++;
      if (done) begin
        lat = k;
        break;
      end
      if (product !== last_prod) hold_ok = 1'b0;
      if (toggle) begin
        start = 1'b1;
        in1   = $urandom;
        in2   = $urandom;
      end
      @(posedge clk);
      #1;
      k++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, 64'(lat), 64'(W + 1));
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'(W));
    chk({tag, "_busy_done_overlap"}, 64'(overlap), 64'd0);
    chk({tag, "_product_hold"}, 64'(hold_ok), 64'd1);
    chk({tag, "_product"}, product, exp_p);
    chk({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf(exp_p)));
    $display("op %s: %h * %h -> product %h ovf %0d (expected %h)", tag, a, b, product, ovf, exp_p);
    last_prod = exp_p;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{a: 32'h3,         b: 32'h5,         p: 64'h0000_0000_0000_000F, btb: 1'b0};
    vecs[1] = '{a: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, p: 64'hFFFF_FFFE_0000_0001, btb: 1'b0};
    vecs[2] = '{a: 32'h0,         b: 32'hDEAD_BEEF, p: 64'h0000_0000_0000_0000, btb: 1'b0};
    vecs[3] = '{a: 32'h1_0000,    b: 32'h1_0000,    p: 64'h0000_0001_0000_0000, btb: 1'b1};
    vecs[4] = '{a: 32'h7,         b: 32'h6,         p: 64'h0000_0000_0000_002A, btb: 1'b0};
    vecs[5] = '{a: 32'h8000_0000, b: 32'h2,         p: 64'h0000_0001_0000_0000, btb: 1'b1};
    vecs[6] = '{a: 32'hFFFF_FFFF, b: 32'h1,         p: 64'h0000_0000_FFFF_FFFF, btb: 1'b0};
    vecs[7] = '{a: 32'h0001_0001, b: 32'h0001_0001, p: 64'h0000_0001_0002_0001, btb: 1'b1};

    // Reset state
    #2;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_product", product, 64'd0);
    chk("reset_ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Vector table; back-to-back entries launch in the done cycle
    for (int i = 0; i < 8; i++) begin
      if (!vecs[i].btb) begin
        @(posedge clk);
        #1;
      end
      launch(vecs[i].a, vecs[i].b);
      finish(vecs[i].a, vecs[i].b, vecs[i].p, 1'b0, $sformatf("vec%0d", i));
    end

    // Start and operands churn during RUN and the DONE state
    @(posedge clk);
    #1;
    launch(32'h1234, 32'h10);
    finish(32'h1234, 32'h10, 64'h1_2340, 1'b1, "ignored_start");
    @(posedge clk);
    #1;
    chk("no_restart_busy", 64'(busy), 64'd0);
    chk("no_restart_done", 64'(done), 64'd0);

    // Reset part-way through RUN
    launch(32'hFFFF_0001, 32'hABCD_1234);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_product", product, 64'd0);
    chk("midrst_ovf", 64'(ovf), 64'd0);
    last_prod = '0;
    @(negedge clk);
    rst_n = 1'b1;
    begin
      bit saw_done;
      saw_done = 1'b0;
      for (int i = 0; i < W + 5; i++) begin
        @(posedge clk);
        #1;
        if (done || busy) saw_done = 1'b1;
      end
      chk("midrst_no_done", 64'(saw_done), 64'd0);
    end
    launch(32'd7, 32'd6);
    finish(32'd7, 32'd6, 64'h2A, 1'b0, "after_reset");

    // Randomized operands checked against the arithmetic reference
    for (int i = 0; i < 16; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = (i % 3 == 0) ? W'($urandom_range(0, 16'hFFFF)) : $urandom;
      b = (i % 3 == 0) ? W'($urandom_range(0, 16'hFFFF)) : $urandom;
      if ($urandom_range(0, 1) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
      launch(a, b);
      finish(a, b, ref_mul(a, b), 1'b0, $sformatf("rnd%0d", i));
    end

    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
